// File: rtl/irq_request_ctrl_4ch.sv
// Four-channel interrupt request front-end: latches requests, masks them into
// req_vec for the priority encoder, and runs a one-at-a-time irq/ack handshake.
module irq_request_ctrl_4ch #(
    parameter logic [3:0] EDGE_TRIG = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic       mask_wr,
    input  logic [3:0] mask_data,
    output logic [3:0] mask,
    output logic [3:0] req_vec,
    output logic       irq,
    output logic [1:0] irq_id,
    input  logic       ack,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Handshake: irq/irq_id are held stable from IDLE->ASSERT until ack is
    // sampled high in ASSERT; ack in any other state is ignored.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] pending;
    logic [3:0] irq_in_q;
    logic [3:0] events;
    logic [3:0] ack_clr;
    logic [1:0] top_id;

    assign events  = (EDGE_TRIG & irq_in & ~irq_in_q) | (~EDGE_TRIG & irq_in);
    assign req_vec = pending & mask;
    assign busy    = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        ack_clr = 4'b0000;
        if (state == ASSERT && ack) begin
            ack_clr[irq_id] = 1'b1;
        end
    end

    // Highest set index of req_vec; bit 3 wins.
    always_comb begin
        top_id = 2'd0;
        if (req_vec[3])      top_id = 2'd3;
        else if (req_vec[2]) top_id = 2'd2;
        else if (req_vec[1]) top_id = 2'd1;
        else                 top_id = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 4'b0000;
            mask     <= 4'b0000;
            irq_in_q <= 4'b0000;
            irq      <= 1'b0;
            irq_id   <= 2'b00;
            state    <= IDLE;
        end else begin
            irq_in_q <= irq_in;
            // A new event on the channel being acknowledged keeps it pending.
            pending  <= (pending & ~ack_clr) | events;
            if (mask_wr) begin
                mask <= mask_data;
            end
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        irq    <= 1'b1;
                        irq_id <= top_id;
                        state  <= ASSERT;
                    end
                end
                ASSERT: begin
                    if (ack) begin
                        irq   <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_request_ctrl_4ch.sv
// Bench for irq_request_ctrl_4ch: vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_irq_request_ctrl_4ch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq_in = 4'b0000;
    logic       mask_wr = 1'b0;
    logic [3:0] mask_data = 4'b0000;
    logic       ack = 1'b0;

    logic [3:0] mask_w  [2];
    logic [3:0] req_w   [2];
    logic       irq_w   [2];
    logic [1:0] id_w    [2];
    logic       busy_w  [2];
    logic [1:0] state_w [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_request_ctrl_4ch #(.EDGE_TRIG(4'b1111)) dut0 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_data(mask_data), .mask(mask_w[0]), .req_vec(req_w[0]),
        .irq(irq_w[0]), .irq_id(id_w[0]), .ack(ack), .busy(busy_w[0]),
        .state_dbg(state_w[0])
    );

    irq_request_ctrl_4ch #(.EDGE_TRIG(4'b1110)) dut1 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
        .mask_data(mask_data), .mask(mask_w[1]), .req_vec(req_w[1]),
        .irq(irq_w[1]), .irq_id(id_w[1]), .ack(ack), .busy(busy_w[1]),
        .state_dbg(state_w[1])
    );

    // Behavioural model: a set of pending flags plus "serving channel id" and
    // "in the one-cycle gap" flags.
    typedef struct packed {
        logic [3:0] pend;
        logic [3:0] prev;
        logic [3:0] msk;
        logic       serving;
        logic [1:0] id;
        logic       gap;
    } mdl_t;

    mdl_t m [2];
    localparam logic [3:0] ET0 = 4'b1111;
    localparam logic [3:0] ET1 = 4'b1110;

    function automatic mdl_t mdl_next(mdl_t s, logic [3:0] et, logic r,
                                      logic [3:0] in, logic wr, logic [3:0] d,
                                      logic a);
        mdl_t n;
        logic [3:0] req;
        n   = s;
        req = s.pend & s.msk;
        if (r) begin
            n = '0;
        end else begin
            if (s.serving) begin
                if (a) begin
                    n.pend[s.id] = 1'b0;
                    n.serving    = 1'b0;
                    n.gap        = 1'b1;
                end
            end else if (s.gap) begin
                n.gap = 1'b0;
            end else if (req != 4'b0000) begin
                n.serving = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (req[i]) n.id = 2'(i);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in[i] && (!et[i] || !s.prev[i])) n.pend[i] = 1'b1;
            end
            n.prev = in;
            if (wr) n.msk = d;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int u, input logic e_irq,
                       input logic [1:0] e_id, input logic [3:0] e_req,
                       input logic e_busy, input logic [3:0] e_mask);
        total++;
        if ({irq_w[u], id_w[u], req_w[u], busy_w[u], mask_w[u]} !==
            {e_irq, e_id, e_req, e_busy, e_mask}) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got irq=%b id=%0d req=%b busy=%b mask=%b want irq=%b id=%0d req=%b busy=%b mask=%b",
                     nm, u, $time, irq_w[u], id_w[u], req_w[u], busy_w[u], mask_w[u],
                     e_irq, e_id, e_req, e_busy, e_mask);
        end
    endtask

    // Apply one cycle of inputs, advance both models, sample 1 ns after the edge.
    task automatic step(input logic r, input logic [3:0] in, input logic wr,
                        input logic [3:0] d, input logic a);
        rst = r; irq_in = in; mask_wr = wr; mask_data = d; ack = a;
        @(posedge clk);
        m[0] = mdl_next(m[0], ET0, r, in, wr, d, a);
        m[1] = mdl_next(m[1], ET1, r, in, wr, d, a);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("model", u, m[u].serving, m[u].id, m[u].pend & m[u].msk,
                m[u].serving | m[u].gap, m[u].msk);
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] in;
        logic       wr;
        logic [3:0] d;
        logic       a;
        logic       e_irq;
        logic [1:0] e_id;
        logic [3:0] e_req;
        logic       e_busy;
        logic [3:0] e_mask;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] in, logic wr, logic [3:0] d,
                                logic a, logic ei, logic [1:0] eid,
                                logic [3:0] er, logic eb, logic [3:0] em);
        vec_t v;
        v.r = r; v.in = in; v.wr = wr; v.d = d; v.a = a;
        v.e_irq = ei; v.e_id = eid; v.e_req = er; v.e_busy = eb; v.e_mask = em;
        tbl.push_back(v);
    endfunction

    initial begin
        m[0] = '0;
        m[1] = '0;
        // single pulse on channel 2
        add(1, 4'h0, 0, 4'h0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
        add(0, 4'h0, 1, 4'hF, 0,  0, 2'd0, 4'b0000, 0, 4'hF);
        add(0, 4'b0100, 0, 4'h0, 0,  0, 2'd0, 4'b0100, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd2, 4'b0100, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd2, 4'b0100, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd2, 4'b0000, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd2, 4'b0000, 0, 4'hF);
        // simultaneous edges on 3,1,0 served 3 -> 1 -> 0
        add(0, 4'b1011, 0, 4'h0, 0,  0, 2'd2, 4'b1011, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd3, 4'b1011, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd3, 4'b0011, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd3, 4'b0011, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd1, 4'b0011, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd1, 4'b0001, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd1, 4'b0001, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd0, 4'b0001, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd0, 4'b0000, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd0, 4'b0000, 0, 4'hF);
        // masked request stays pending, released by a mask write
        add(0, 4'h0, 1, 4'h0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
        add(0, 4'b0010, 0, 4'h0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
        add(0, 4'h0, 1, 4'b0010, 0,  0, 2'd0, 4'b0010, 0, 4'b0010);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd1, 4'b0010, 1, 4'b0010);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd1, 4'b0000, 1, 4'b0010);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd1, 4'b0000, 0, 4'b0010);
        // no preemption: channel 3 arrives while channel 0 is signalled
        add(0, 4'h0, 1, 4'hF, 0,  0, 2'd1, 4'b0000, 0, 4'hF);
        add(0, 4'b0001, 0, 4'h0, 0,  0, 2'd1, 4'b0001, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd0, 4'b0001, 1, 4'hF);
        add(0, 4'b1000, 0, 4'h0, 0,  1, 2'd0, 4'b1001, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd0, 4'b1001, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd0, 4'b1000, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd0, 4'b1000, 0, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  1, 2'd3, 4'b1000, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 1,  0, 2'd3, 4'b0000, 1, 4'hF);
        add(0, 4'h0, 0, 4'h0, 0,  0, 2'd3, 4'b0000, 0, 4'hF);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].in, tbl[i].wr, tbl[i].d, tbl[i].a);
            chk($sformatf("vec%0d", i), 0, tbl[i].e_irq, tbl[i].e_id,
                tbl[i].e_req, tbl[i].e_busy, tbl[i].e_mask);
        end

        // level channel 0 on dut1 held high across ack is re-signalled
        step(1, 4'h0, 0, 4'h0, 0);
        chk("lvl_reset", 1, 0, 2'd0, 4'b0000, 0, 4'h0);
        step(0, 4'h0, 1, 4'hF, 0);
        step(0, 4'b0001, 0, 4'h0, 0);
        chk("lvl_set", 1, 0, 2'd0, 4'b0001, 0, 4'hF);
        step(0, 4'b0001, 0, 4'h0, 0);
        chk("lvl_irq", 1, 1, 2'd0, 4'b0001, 1, 4'hF);
        step(0, 4'b0001, 0, 4'h0, 1);
        chk("lvl_ack_setwins", 1, 0, 2'd0, 4'b0001, 1, 4'hF);
        step(0, 4'b0001, 0, 4'h0, 0);
        chk("lvl_gap_done", 1, 0, 2'd0, 4'b0001, 0, 4'hF);
        step(0, 4'b0001, 0, 4'h0, 0);
        chk("lvl_reassert", 1, 1, 2'd0, 4'b0001, 1, 4'hF);
        step(0, 4'h0, 0, 4'h0, 1);
        chk("lvl_drop_ack", 1, 0, 2'd0, 4'b0000, 1, 4'hF);
        step(0, 4'h0, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 0);
        chk("lvl_quiet", 1, 0, 2'd0, 4'b0000, 0, 4'hF);

        // reset while irq is up discards everything; a late ack does nothing
        step(0, 4'b1010, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 0);
        chk("rst_pre", 0, 1, 2'd3, 4'b1010, 1, 4'hF);
        step(1, 4'h0, 0, 4'h0, 0);
        chk("rst_mid", 0, 0, 2'd0, 4'b0000, 0, 4'h0);
        step(0, 4'h0, 0, 4'h0, 1);
        chk("rst_late_ack", 0, 0, 2'd0, 4'b0000, 0, 4'h0);
        step(0, 4'h0, 1, 4'hF, 0);
        chk("rst_pend_gone", 0, 0, 2'd0, 4'b0000, 0, 4'hF);
        step(0, 4'h0, 0, 4'h0, 0);
        chk("rst_no_irq", 0, 0, 2'd0, 4'b0000, 0, 4'hF);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) == 0),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
